// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// State encoding, hold-counter width and one-hot to binary index conversion.
package rr_arb_pkg;

   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned MAX_REQ = 32;
   localparam int unsigned MAX_IDX = 5;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } rr_state_t;

   // Binary position of the set bit; caller guarantees zero or one-hot input.
   function automatic logic [MAX_IDX-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [MAX_IDX-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | MAX_IDX'(i);
         end
      end
      return idx;
   endfunction

endpackage : rr_arb_pkg

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo N_REQ.
// Double-width masked priority encoder; purely combinational.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] win_c,
   output logic             found_c
);

   localparam int unsigned W2 = 2 * N_REQ;

   logic [N_REQ-1:0] hi_mask;
   logic [W2-1:0]    dbl;
   logic [W2-1:0]    iso;

   // Lower copy keeps only bits at or above ptr; upper copy supplies the wrap.
   assign hi_mask = {N_REQ{1'b1}} << ptr;
   assign dbl     = {req, req & hi_mask};
   assign iso     = dbl & (~dbl + W2'(1));

   assign win_c   = iso[N_REQ-1:0] | iso[W2-1:N_REQ];
   assign found_c = |req;

endmodule : rr_pick

// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with registered grant and bounded per-grant tenure.
// Optional RR_LOCK_EN adds a Lock input that suppresses the tenure timeout.
module rr_arbiter_hold
   import rr_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned IDX_W    = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              rst,
`ifdef RR_LOCK_EN
   input  logic              Lock,
`endif
   input  logic [N_REQ-1:0]  Priority_bus,
   output logic [N_REQ-1:0]  Grant_onehot,
   output logic [IDX_W-1:0]  Next_priority,
   output logic              Data_Valid,
   output logic [HOLD_W-1:0] Hold_cnt
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

   rr_state_t         state_q;
   rr_state_t         state_d;
   logic [IDX_W-1:0]  ptr_q;
   logic [IDX_W-1:0]  ptr_d;
   logic [IDX_W-1:0]  ptr_rot;
   logic [IDX_W-1:0]  pick_ptr;
   logic [N_REQ-1:0]  win_c;
   logic              found_c;
   logic [IDX_W-1:0]  win_idx;
   logic [N_REQ-1:0]  grant_d;
   logic [IDX_W-1:0]  idx_d;
   logic              valid_d;
   logic [HOLD_W-1:0] hold_d;
   logic              lock_c;
   logic              owner_req_c;
   logic              timeout_c;

`ifdef RR_LOCK_EN
   assign lock_c = Lock & Data_Valid;
`else
   assign lock_c = 1'b0;
`endif

   // Owner's own request and tenure expiry decide whether the grant is released.
   assign owner_req_c = Priority_bus[Next_priority];
   assign timeout_c   = !lock_c && (Hold_cnt >= HOLD_LAST);

   // On release the search restarts just past the current owner.
   assign ptr_rot  = (Next_priority == IDX_LAST) ? '0 : Next_priority + IDX_W'(1);
   assign pick_ptr = (state_q == GRANT) ? ptr_rot : ptr_q;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (Priority_bus),
      .ptr     (pick_ptr),
      .win_c   (win_c),
      .found_c (found_c)
   );

   assign win_idx = IDX_W'(onehot_to_idx(MAX_REQ'(win_c)));

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = Grant_onehot;
      idx_d   = Next_priority;
      valid_d = Data_Valid;
      hold_d  = Hold_cnt;

      case (state_q)
         IDLE: begin
            if (found_c) begin
               state_d = GRANT;
               grant_d = win_c;
               idx_d   = win_idx;
               valid_d = 1'b1;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (owner_req_c && !timeout_c) begin
               hold_d = (Hold_cnt == HOLD_SAT) ? Hold_cnt : Hold_cnt + HOLD_W'(1);
            end else begin
               ptr_d = ptr_rot;
               if (found_c) begin
                  grant_d = win_c;
                  idx_d   = win_idx;
                  valid_d = 1'b1;
                  hold_d  = '0;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  idx_d   = '0;
                  valid_d = 1'b0;
                  hold_d  = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         Grant_onehot  <= '0;
         Next_priority <= '0;
         Data_Valid    <= 1'b0;
         Hold_cnt      <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         Grant_onehot  <= grant_d;
         Next_priority <= idx_d;
         Data_Valid    <= valid_d;
         Hold_cnt      <= hold_d;
      end
   end

endmodule : rr_arbiter_hold

// File: tb/tb_rr_arbiter_hold.sv
// Self-checking bench for rr_arbiter_hold (N_REQ=4, MAX_HOLD=4): directed table,
// hand-written corner sequences and randomized traffic against a queue-free reference model.
module tb_rr_arbiter_hold;

   localparam int N  = 4;
   localparam int MH = 4;

   logic       clk;
   logic       rst;
   logic       lock;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] idx;
   logic       valid;
   logic [7:0] hold;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_valid, m_owner, m_hold, m_ptr;

   rr_arbiter_hold #(
      .N_REQ    (N),
      .MAX_HOLD (MH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
`ifdef RR_LOCK_EN
      .Lock          (lock),
`endif
      .Priority_bus  (req),
      .Grant_onehot  (grant),
      .Next_priority (idx),
      .Data_Valid    (valid),
      .Hold_cnt      (hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [3:0] req;
      logic [3:0] g;
      logic [1:0] i;
      bit         v;
      logic [7:0] h;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit r, logic [3:0] q, logic [3:0] g, logic [1:0] i, bit v, logic [7:0] h);
      vec_t e;
      e.rst = r; e.req = q; e.g = g; e.i = i; e.v = v; e.h = h;
      vecs.push_back(e);
   endfunction

   function automatic int search(logic [3:0] r, int from);
      for (int k = 0; k < N; k++) begin
         if (r[(from + k) % N]) return (from + k) % N;
      end
      return -1;
   endfunction

   task automatic model_step(bit r_rst, logic [3:0] r, bit lk);
      int w;
      if (r_rst) begin
         m_valid = 0; m_owner = 0; m_hold = 0; m_ptr = 0;
      end else if (m_valid == 0) begin
         w = search(r, m_ptr);
         if (w >= 0) begin
            m_valid = 1; m_owner = w; m_hold = 0;
         end
      end else if (r[m_owner] && (lk || m_hold < MH - 1)) begin
         if (m_hold < 255) m_hold++;
      end else begin
         m_ptr = (m_owner + 1) % N;
         w = search(r, m_ptr);
         if (w >= 0) begin
            m_owner = w; m_hold = 0;
         end else begin
            m_valid = 0; m_owner = 0; m_hold = 0;
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model with what the DUT saw, sample after the edge.
   task automatic apply(bit r_rst, logic [3:0] r, bit lk);
      bit lk_eff;
`ifdef RR_LOCK_EN
      lk_eff = lk;
`else
      lk_eff = 1'b0;
`endif
      rst  = r_rst;
      req  = r;
      lock = lk;
      @(posedge clk);
      model_step(r_rst, r, lk_eff);
      #1;
   endtask

   task automatic chk_model(string tag);
      logic [3:0] eg;
      eg = (m_valid != 0) ? 4'(1 << m_owner) : 4'b0000;
      chk({tag, "_grant"}, 32'(grant), 32'(eg));
      chk({tag, "_idx"},   32'(idx),   32'(m_valid != 0 ? m_owner : 0));
      chk({tag, "_valid"}, 32'(valid), 32'(m_valid));
      chk({tag, "_hold"},  32'(hold),  32'(m_hold));
      chk({tag, "_onehot0"}, 32'($onehot0(grant)), 32'd1);
   endtask

   initial begin
      logic [3:0] prev_req;
      logic [3:0] r;
      bit         lk;
      bit         rr;

      rst = 1'b1; req = '0; lock = 1'b0;

      // Directed table: single requester timeout, full rotation, early drop, mid-grant reset
      add(1, 4'b0000, 4'b0000, 2'd0, 0, 8'd0);
      add(1, 4'b0100, 4'b0000, 2'd0, 0, 8'd0);
      for (int k = 0; k < 4; k++) add(0, 4'b0100, 4'b0100, 2'd2, 1, 8'(k));
      add(0, 4'b0100, 4'b0100, 2'd2, 1, 8'd0);
      add(0, 4'b0100, 4'b0100, 2'd2, 1, 8'd1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0, 8'd0);
      add(1, 4'b1111, 4'b0000, 2'd0, 0, 8'd0);
      for (int k = 0; k < 16; k++) add(0, 4'b1111, 4'(1 << (k / 4)), 2'(k / 4), 1, 8'(k % 4));
      add(0, 4'b1111, 4'b0001, 2'd0, 1, 8'd0);
      add(1, 4'b0000, 4'b0000, 2'd0, 0, 8'd0);
      add(0, 4'b0010, 4'b0010, 2'd1, 1, 8'd0);
      add(0, 4'b0010, 4'b0010, 2'd1, 1, 8'd1);
      add(0, 4'b1001, 4'b1000, 2'd3, 1, 8'd0);
      add(0, 4'b1001, 4'b1000, 2'd3, 1, 8'd1);
      add(1, 4'b1001, 4'b0000, 2'd0, 0, 8'd0);
      add(0, 4'b1111, 4'b0001, 2'd0, 1, 8'd0);

      foreach (vecs[n]) begin
         apply(vecs[n].rst, vecs[n].req, 1'b0);
         chk($sformatf("vec%0d_grant", n), 32'(grant), 32'(vecs[n].g));
         chk($sformatf("vec%0d_idx", n),   32'(idx),   32'(vecs[n].i));
         chk($sformatf("vec%0d_valid", n), 32'(valid), 32'(vecs[n].v));
         chk($sformatf("vec%0d_hold", n),  32'(hold),  32'(vecs[n].h));
      end

      // Counting pattern: idle only ever follows an all-zero request cycle
      apply(1, 4'b0000, 1'b0);
      prev_req = 4'b0000;
      for (int c = 0; c < 32; c++) begin
         r = 4'(c % 16);
         apply(0, r, 1'b0);
         chk_model("count");
         if (!valid) chk("count_idle_after_zero", 32'(r), 32'd0);
         prev_req = r;
      end

`ifdef RR_LOCK_EN
      // Lock holds owner 0 past the timeout; dropping Lock rotates to 1 at once
      apply(1, 4'b0000, 1'b0);
      for (int k = 0; k < 10; k++) begin
         apply(0, 4'b0011, 1'b1);
         chk("lock_grant", 32'(grant), 32'h1);
         chk("lock_hold",  32'(hold),  32'(k));
      end
      apply(0, 4'b0011, 1'b0);
      chk("unlock_grant", 32'(grant), 32'h2);
      chk("unlock_idx",   32'(idx),   32'd1);
      chk("unlock_hold",  32'(hold),  32'd0);
`endif

      // Randomized traffic with sticky requests so tenures run to timeout
      apply(1, 4'b0000, 1'b0);
      r  = 4'b0000;
      lk = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rr = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 9) < 3) r = 4'($urandom);
         if ($urandom_range(0, 15) == 0) lk = ~lk;
         apply(rr, r, lk);
         chk_model("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rr_arbiter_hold
